// File: rtl/filter_pkg.sv
// Purpose: shared types and constants for the IPv4 rule filter (rule entry layout, FSM states, match helper).
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package filter_pkg;

    localparam int IPV4_ADDR_W    = 32;
    localparam int BYTE_CNT_W     = 16;
    localparam int DEF_NUM_RULES  = 4;
    localparam int DEF_SRC_OFFSET = 26;
    localparam int DEF_DST_OFFSET = 30;

    typedef struct packed {
        logic [IPV4_ADDR_W-1:0] value;
        logic [IPV4_ADDR_W-1:0] mask;   // 1 = bit compared
        logic                   dst;    // 0 = source IP, 1 = destination IP
        logic                   allow;  // action on match
        logic                   en;
    } rule_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Masked compare of one entry against whichever captured field it selects.
    function automatic logic rule_hit(input rule_t r,
                                      input logic [IPV4_ADDR_W-1:0] src_ip,
                                      input logic [IPV4_ADDR_W-1:0] dst_ip);
        logic [IPV4_ADDR_W-1:0] field;
        field = r.dst ? dst_ip : src_ip;
        return r.en && (((field ^ r.value) & r.mask) == '0);
    endfunction

endpackage

// File: rtl/rule_match_prio.sv
// Purpose: NUM_RULES-way masked address compare with lowest-index-wins priority encode.
// Latency: combinational, 0 cycles.
// Backpressure: none; evaluated continuously, the caller decides when to sample.
// Ports: rules (table), src_ip/dst_ip (captured fields) -> hit, hit_idx, allow.
import filter_pkg::*;

module rule_match_prio #(
    parameter int NUM_RULES = DEF_NUM_RULES,
    parameter int IDX_W     = 2
) (
    input  rule_t                  rules [NUM_RULES],
    input  logic [IPV4_ADDR_W-1:0] src_ip,
    input  logic [IPV4_ADDR_W-1:0] dst_ip,
    output logic                   hit,
    output logic [IDX_W-1:0]       hit_idx,
    output logic                   allow
);

    // Walk from the highest index down so the lowest matching entry is the
    // last one written and therefore wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        allow   = 1'b0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (rule_hit(rules[i], src_ip, dst_ip)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
                allow   = rules[i].allow;
            end
        end
    end

endmodule

// File: rtl/ip_rule_filter.sv
// Purpose: byte-serial IPv4 src/dst capture, programmable masked rule table, one registered verdict per packet.
// Latency: verdict and done one cycle after the edge accepting the last_in byte.
// Backpressure: none; valid_in stalls are absorbed indefinitely, back-to-back packets need no bubble.
// Ports: clk/rst (sync, active high); data_in/valid_in/last_in byte stream;
//        rule_wr/rule_idx/rule_value/rule_mask/rule_dst/rule_allow/rule_en table write;
//        packet_allowed/done/hit/hit_idx/runt verdict.
// Option: FILTER_STATS_EN adds 32-bit wrapping allow_count/block_count outputs.
import filter_pkg::*;

module ip_rule_filter #(
    parameter int NUM_RULES     = DEF_NUM_RULES,
    parameter int SRC_OFFSET    = DEF_SRC_OFFSET,
    parameter int DST_OFFSET    = DEF_DST_OFFSET,
    parameter bit DEFAULT_ALLOW = 1'b1,
    localparam int IDX_W        = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             data_in,
    input  logic                   valid_in,
    input  logic                   last_in,
    input  logic                   rule_wr,
    input  logic [IDX_W-1:0]       rule_idx,
    input  logic [IPV4_ADDR_W-1:0] rule_value,
    input  logic [IPV4_ADDR_W-1:0] rule_mask,
    input  logic                   rule_dst,
    input  logic                   rule_allow,
    input  logic                   rule_en,
    output logic                   packet_allowed,
    output logic                   done,
    output logic                   hit,
    output logic [IDX_W-1:0]       hit_idx,
`ifdef FILTER_STATS_EN
    output logic [31:0]            allow_count,
    output logic [31:0]            block_count,
`endif
    output logic                   runt
);

    localparam int LAST_BYTE = ((SRC_OFFSET > DST_OFFSET) ? SRC_OFFSET : DST_OFFSET) + 3;
    localparam logic [BYTE_CNT_W-1:0] SRC_LO  = BYTE_CNT_W'(SRC_OFFSET);
    localparam logic [BYTE_CNT_W-1:0] SRC_HI  = BYTE_CNT_W'(SRC_OFFSET + 3);
    localparam logic [BYTE_CNT_W-1:0] DST_LO  = BYTE_CNT_W'(DST_OFFSET);
    localparam logic [BYTE_CNT_W-1:0] DST_HI  = BYTE_CNT_W'(DST_OFFSET + 3);
    localparam logic [BYTE_CNT_W-1:0] LAST_IX = BYTE_CNT_W'(LAST_BYTE);

    state_e                  state_q, state_d;
    logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
    logic [IPV4_ADDR_W-1:0]  src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
    rule_t                   rules_q [NUM_RULES];
    rule_t                   rules_d [NUM_RULES];
    logic                    allowed_q, allowed_d, done_q, done_d, hit_q, hit_d, runt_q, runt_d;
    logic [IDX_W-1:0]        hit_idx_q, hit_idx_d;
    logic                    decide, is_runt;
    logic                    m_hit, m_allow;
    logic [IDX_W-1:0]        m_idx;

    assign decide = valid_in && last_in;

    // Counter and field capture. The decision looks at the _d fields so a
    // byte completing a field in the deciding cycle is included.
    always_comb begin
        cnt_d    = cnt_q;
        src_ip_d = src_ip_q;
        dst_ip_d = dst_ip_q;
        if (valid_in) begin
            if (last_in)
                cnt_d = '0;
            else if (cnt_q != '1)
                cnt_d = cnt_q + 1'b1;
            if (cnt_q >= SRC_LO && cnt_q <= SRC_HI)
                src_ip_d = {src_ip_q[IPV4_ADDR_W-9:0], data_in};
            if (cnt_q >= DST_LO && cnt_q <= DST_HI)
                dst_ip_d = {dst_ip_q[IPV4_ADDR_W-9:0], data_in};
        end
    end

    // Table writes land on the next edge; the matcher reads rules_q, so a
    // write coincident with a deciding byte is not seen by that decision.
    always_comb begin
        rules_d = rules_q;
        if (rule_wr && (32'(rule_idx) < NUM_RULES)) begin
            rules_d[rule_idx].value = rule_value;
            rules_d[rule_idx].mask  = rule_mask;
            rules_d[rule_idx].dst   = rule_dst;
            rules_d[rule_idx].allow = rule_allow;
            rules_d[rule_idx].en    = rule_en;
        end
    end

    rule_match_prio #(
        .NUM_RULES (NUM_RULES),
        .IDX_W     (IDX_W)
    ) u_match (
        .rules   (rules_q),
        .src_ip  (src_ip_d),
        .dst_ip  (dst_ip_d),
        .hit     (m_hit),
        .hit_idx (m_idx),
        .allow   (m_allow)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (valid_in)
            state_d = last_in ? ST_IDLE : ST_RUN;
    end

    // FSM: outputs. A last byte accepted in IDLE is a one-byte packet; in RUN
    // the fields are complete only once the highest field byte is the one
    // being accepted or already behind us.
    always_comb begin
        is_runt   = (state_q == ST_IDLE) || (cnt_q < LAST_IX);
        done_d    = decide;
        allowed_d = allowed_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        runt_d    = runt_q;
        if (decide) begin
            if (is_runt) begin
                allowed_d = 1'b0;
                hit_d     = 1'b0;
                hit_idx_d = '0;
                runt_d    = 1'b1;
            end else begin
                allowed_d = m_hit ? m_allow : DEFAULT_ALLOW;
                hit_d     = m_hit;
                hit_idx_d = m_hit ? m_idx : '0;
                runt_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            src_ip_q  <= '0;
            dst_ip_q  <= '0;
            rules_q   <= '{default: '0};
            allowed_q <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            runt_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            src_ip_q  <= src_ip_d;
            dst_ip_q  <= dst_ip_d;
            rules_q   <= rules_d;
            allowed_q <= allowed_d;
            done_q    <= done_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
            runt_q    <= runt_d;
        end
    end

    assign packet_allowed = allowed_q;
    assign done           = done_q;
    assign hit            = hit_q;
    assign hit_idx        = hit_idx_q;
    assign runt           = runt_q;

`ifdef FILTER_STATS_EN
    logic [31:0] allow_cnt_q, allow_cnt_d, block_cnt_q, block_cnt_d;

    // Counts follow the verdict being registered; runts land in block_count
    // because their verdict is always blocked. Natural wrap at 2^32.
    always_comb begin
        allow_cnt_d = allow_cnt_q;
        block_cnt_d = block_cnt_q;
        if (decide) begin
            if (allowed_d) allow_cnt_d = allow_cnt_q + 32'd1;
            else           block_cnt_d = block_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            allow_cnt_q <= '0;
            block_cnt_q <= '0;
        end else begin
            allow_cnt_q <= allow_cnt_d;
            block_cnt_q <= block_cnt_d;
        end
    end

    assign allow_count = allow_cnt_q;
    assign block_count = block_cnt_q;
`endif

endmodule

// File: tb/tb_ip_rule_filter.sv
module tb_ip_rule_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        valid_in, last_in;
    logic        rule_wr;
    logic [1:0]  rule_idx;
    logic [31:0] rule_value, rule_mask;
    logic        rule_dst, rule_allow, rule_en;
    logic        packet_allowed, done, hit, runt;
    logic [1:0]  hit_idx;
`ifdef FILTER_STATS_EN
    logic [31:0] allow_count, block_count;
`endif

    always #5 clk = ~clk;

    ip_rule_filter #(
        .NUM_RULES     (4),
        .SRC_OFFSET    (26),
        .DST_OFFSET    (30),
        .DEFAULT_ALLOW (1'b0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .last_in        (last_in),
        .rule_wr        (rule_wr),
        .rule_idx       (rule_idx),
        .rule_value     (rule_value),
        .rule_mask      (rule_mask),
        .rule_dst       (rule_dst),
        .rule_allow     (rule_allow),
        .rule_en        (rule_en),
        .packet_allowed (packet_allowed),
        .done           (done),
        .hit            (hit),
        .hit_idx        (hit_idx),
`ifdef FILTER_STATS_EN
        .allow_count    (allow_count),
        .block_count    (block_count),
`endif
        .runt           (runt)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pkt_byte(input logic [31:0] s, input logic [31:0] d, input int i);
        if (i >= 26 && i <= 29) return s[8*(29-i) +: 8];
        if (i >= 30 && i <= 33) return d[8*(33-i) +: 8];
        return 8'(i * 7 + 3);
    endfunction

    task automatic write_rule(input logic [1:0] idx, input logic [31:0] val, input logic [31:0] msk,
                              input bit dst, input bit alw, input bit en);
        rule_idx = idx; rule_value = val; rule_mask = msk;
        rule_dst = dst; rule_allow = alw; rule_en = en;
        rule_wr = 1'b1;
        @(posedge clk); #1;
        rule_wr = 1'b0;
    endtask

    // Returns #1 after the edge accepting the last byte, i.e. when done should be high.
    task automatic send_pkt(input logic [31:0] s, input logic [31:0] d, input int len,
                            input bit stall, input bit wr_last);
        for (int i = 0; i < len; i++) begin
            if (stall && $urandom_range(0, 2) == 0) begin
                valid_in = 1'b0;
                last_in  = 1'b1;   // must be ignored while valid_in is low
                data_in  = 8'hEE;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            valid_in = 1'b1;
            data_in  = pkt_byte(s, d, i);
            last_in  = (i == len - 1);
            rule_wr  = wr_last && (i == len - 1);
            @(posedge clk); #1;
            rule_wr  = 1'b0;
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic check_verdict(input string tag, input bit ea, input bit eh,
                                 input logic [1:0] ei, input bit er);
        chk({tag, ".done"},    done,           1);
        chk({tag, ".allowed"}, packet_allowed, ea);
        chk({tag, ".hit"},     hit,            eh);
        chk({tag, ".hit_idx"}, hit_idx,        ei);
        chk({tag, ".runt"},    runt,           er);
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  widx;
        logic [31:0] wval;
        logic [31:0] wmask;
        bit          wdst, wallow, wen;
        logic [31:0] src, dst;
        int          len;
        bit          ea, eh;
        logic [1:0]  ei;
        bit          er;
    } vec_t;

    vec_t vt[13];

    initial begin
        int c0;
        //           wr idx  value         mask          d  a  e   src           dst           len ea eh ei er
        vt[0]  = '{1, 2'd0, 32'hC0A80164, 32'hFFFFFFFF, 0, 0, 1, 32'hC0A80164, 32'h01020304, 40, 0, 1, 2'd0, 0};
        vt[1]  = '{1, 2'd0, 32'hC0A80164, 32'hFFFFFFFF, 0, 0, 0, 32'hC0A80164, 32'h01020304, 40, 0, 0, 2'd0, 0};
        vt[2]  = '{1, 2'd1, 32'hC0A80100, 32'hFFFFFF00, 0, 1, 1, 32'hC0A80164, 32'h01020304, 40, 1, 1, 2'd1, 0};
        vt[3]  = '{1, 2'd2, 32'hC0A80164, 32'hFFFFFFFF, 0, 0, 1, 32'hC0A80164, 32'h01020304, 40, 1, 1, 2'd1, 0};
        vt[4]  = '{0, 2'd0, 32'h0,        32'h0,        0, 0, 0, 32'hC0A80201, 32'h01020304, 40, 0, 0, 2'd0, 0};
        vt[5]  = '{1, 2'd0, 32'h0A000001, 32'hFFFFFFFF, 1, 1, 1, 32'h0B000000, 32'h0A000001, 40, 1, 1, 2'd0, 0};
        vt[6]  = '{0, 2'd0, 32'h0,        32'h0,        0, 0, 0, 32'h0B000000, 32'h0A000002, 40, 0, 0, 2'd0, 0};
        vt[7]  = '{1, 2'd3, 32'h0,        32'h0,        0, 1, 1, 32'h0B000000, 32'h0A000002, 40, 1, 1, 2'd3, 0};
        vt[8]  = '{0, 2'd0, 32'h0,        32'h0,        0, 0, 0, 32'h0B000000, 32'h0A000002, 20, 0, 0, 2'd0, 1};
        vt[9]  = '{0, 2'd0, 32'h0,        32'h0,        0, 0, 0, 32'h0B000000, 32'h0A000002,  1, 0, 0, 2'd0, 1};
        vt[10] = '{0, 2'd0, 32'h0,        32'h0,        0, 0, 0, 32'h0B000000, 32'h0A000002, 33, 0, 0, 2'd0, 1};
        vt[11] = '{0, 2'd0, 32'h0,        32'h0,        0, 0, 0, 32'h0B000000, 32'h0A000002, 34, 1, 1, 2'd3, 0};
        vt[12] = '{0, 2'd0, 32'h0,        32'h0,        0, 0, 0, 32'h0A000001, 32'h0B000000, 40, 1, 1, 2'd3, 0};

        rst = 1'b1; data_in = '0; valid_in = 1'b0; last_in = 1'b0;
        rule_wr = 1'b0; rule_idx = '0; rule_value = '0; rule_mask = '0;
        rule_dst = 1'b0; rule_allow = 1'b0; rule_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.allowed", packet_allowed, 0);
        chk("reset.done",    done,           0);
        chk("reset.hit",     hit,            0);
        chk("reset.hit_idx", hit_idx,        0);
        chk("reset.runt",    runt,           0);
`ifdef FILTER_STATS_EN
        chk("reset.allow_count", allow_count, 0);
        chk("reset.block_count", block_count, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven packets
        for (int k = 0; k < 13; k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            if (vt[k].wr)
                write_rule(vt[k].widx, vt[k].wval, vt[k].wmask, vt[k].wdst, vt[k].wallow, vt[k].wen);
            c0 = done_cnt;
            send_pkt(vt[k].src, vt[k].dst, vt[k].len, 1'b0, 1'b0);
            check_verdict(tag, vt[k].ea, vt[k].eh, vt[k].ei, vt[k].er);
            @(posedge clk); #1;
            chk({tag, ".pulse_low"}, done, 0);
            chk({tag, ".pulse_count"}, done_cnt - c0, 1);
        end

        // Back-to-back with stalls; entry1 disabled in the same cycle as P1's last byte
        write_rule(2'd3, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        rule_idx = 2'd1; rule_value = 32'hC0A80100; rule_mask = 32'hFFFFFF00;
        rule_dst = 1'b0; rule_allow = 1'b1; rule_en = 1'b0;
        c0 = done_cnt;
        send_pkt(32'hC0A80164, 32'h0A000009, 40, 1'b1, 1'b1);
        check_verdict("b2b.p1", 1, 1, 2'd1, 0);
        send_pkt(32'hC0A80164, 32'h0A000009, 40, 1'b1, 1'b0);
        check_verdict("b2b.p2", 0, 1, 2'd2, 0);
        send_pkt(32'h0B000000, 32'h0A000001, 40, 1'b1, 1'b0);
        check_verdict("b2b.p3", 1, 1, 2'd0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b.pulse_count", done_cnt - c0, 3);

        // Reset while byte 15 is on the bus
        c0 = done_cnt;
        for (int i = 0; i < 15; i++) begin
            valid_in = 1'b1; last_in = 1'b0;
            data_in = pkt_byte(32'hC0A80164, 32'h0A000001, i);
            @(posedge clk); #1;
        end
        data_in = pkt_byte(32'hC0A80164, 32'h0A000001, 15);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; valid_in = 1'b0;
        chk("rst.allowed", packet_allowed, 0);
        chk("rst.done",    done,           0);
        chk("rst.hit",     hit,            0);
        chk("rst.hit_idx", hit_idx,        0);
        chk("rst.runt",    runt,           0);
`ifdef FILTER_STATS_EN
        chk("rst.allow_count", allow_count, 0);
        chk("rst.block_count", block_count, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst.no_done", done_cnt - c0, 0);
        // Entry0 would have allowed this by destination; a cleared table gives the default.
        send_pkt(32'hC0A80164, 32'h0A000001, 40, 1'b0, 1'b0);
        check_verdict("rst.cleared", 0, 0, 2'd0, 0);
        write_rule(2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        send_pkt(32'h01010101, 32'h02020202, 40, 1'b0, 1'b0);
        check_verdict("post.a1", 1, 1, 2'd0, 0);
        send_pkt(32'h03030303, 32'h04040404, 40, 1'b0, 1'b0);
        check_verdict("post.a2", 1, 1, 2'd0, 0);
        @(posedge clk); #1;
`ifdef FILTER_STATS_EN
        chk("stats.allow_count", allow_count, 2);
        chk("stats.block_count", block_count, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ip_rule_filter.md
# ip_rule_filter

Parametrised successor to the single-address packet filter. It inspects a byte-serial Ethernet/IPv4 stream and extracts the source and destination IPv4 addresses at configurable offsets. Each packet is matched against a run-time-programmable table of masked rules, each carrying its own allow/block action. It sits between the receive byte stream and the forwarding logic and emits one registered verdict per packet.

## Interface
Parameters:
- NUM_RULES, 4, number of rule entries (1–16)
- SRC_OFFSET, 26, byte index of the first source-IP byte
- DST_OFFSET, 30, byte index of the first destination-IP byte
- DEFAULT_ALLOW, 1, action when no rule matches

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  8  packet byte
- valid_in  in  1  data_in valid this cycle
- last_in  in  1  qualifies the final byte of a packet (valid only with valid_in)
- rule_wr  in  1  rule-table write strobe
- rule_idx  in  $clog2(NUM_RULES) (min 1)  entry to write
- rule_value  in  32  address compare value
- rule_mask  in  32  1 = bit compared
- rule_dst  in  1  0 = compare source IP, 1 = compare destination IP
- rule_allow  in  1  action on match
- rule_en  in  1  entry enable
- packet_allowed  out  1  verdict; held until next verdict
- done  out  1  one-cycle verdict-valid pulse
- hit  out  1  a rule matched (held with verdict)
- hit_idx  out  $clog2(NUM_RULES)  matching entry (held with verdict)
- runt  out  1  packet ended before both fields were captured (held with verdict)

## Operation
- A byte counter (16 bit, saturating at 0xFFFF) counts accepted bytes (valid_in=1) within a packet. It clears after the last_in byte.
- Bytes at SRC_OFFSET..+3 and DST_OFFSET..+3 are shifted big-endian into src_ip and dst_ip. The first byte lands in bits [31:24].
- Two states: IDLE (counter 0) and RUN (mid-packet). Any accepted byte moves IDLE→RUN. An accepted last_in byte returns to IDLE and triggers the decision.
- Decision uses the captured fields, including the byte accepted in the same cycle if it completes a field.
- Match condition for entry i: rule_en[i] && ((field ^ value[i]) & mask[i]) == 0. The field is src_ip or dst_ip per rule_dst[i].
- Priority: the lowest-index matching entry wins. Its action sets packet_allowed, hit=1, and hit_idx=i.
- No match: packet_allowed=DEFAULT_ALLOW, hit=0, hit_idx=0.
- Runt: if last_in arrives before byte max(SRC_OFFSET,DST_OFFSET)+3 is accepted, then packet_allowed=0, runt=1, hit=0. Rules are not evaluated.
- A single-byte packet (last_in on the first byte) is a runt.
- Rule writes take effect on the next clock. A write in the same cycle as the deciding byte is not seen by that decision. Writes are permitted at any time.
- An all-zero mask with rule_en=1 matches everything.

## Timing
- Reset values:
  - packet_allowed=0, done=0, hit=0, hit_idx=0, runt=0.
  - Counter=0, state IDLE.
  - All rule entries disabled (rule_en=0, value/mask=0).
- Latency: done is asserted in the cycle after the clock edge that accepts the last_in byte, i.e. 1 cycle. All verdict outputs update on that same edge.
- Back-to-back packets: the next packet's first byte may be accepted the cycle right after last_in. There are no bubbles, and each packet produces exactly one done pulse.
- valid_in low mid-packet: the stall is held indefinitely and the counter is unchanged.
- last_in with valid_in=0 is ignored.
- rst mid-packet: the packet is discarded, no done is produced, and the rule table is cleared.

## Configuration
- FILTER_STATS_EN defined: adds outputs allow_count and block_count, each 32 bit.
  - Reset to 0.
  - Increment on each done pulse according to packet_allowed; runts count as blocked.
  - Wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters are absent. Verdict behaviour is identical.

## Structure
- Shared package filter_pkg:
  - rule_t struct (value, mask, dst, allow, en)
  - IPV4_ADDR_W=32
  - BYTE_CNT_W=16
  - Default offset constants
- Sub-module rule_match_prio: combinational NUM_RULES-way masked compare plus lowest-index priority encoder. Outputs hit, hit_idx and allow.
- The top level holds the counter, field capture, FSM, rule table registers and output registers.

## Test plan
- Blocked source:
  - Setup: entry0 = {value C0A80164, mask FFFFFFFF, dst 0, allow 0, en 1}. Then a 40-byte packet with source IP 192.168.1.100 at bytes 26–29.
  - Expect: done 1 cycle after last byte; packet_allowed=0, hit=1, hit_idx=0.
- Priority and subnet:
  - Setup: entry1 = {C0A80100, FFFFFF00, allow 1}, entry2 = {C0A80164, FFFFFFFF, allow 0}. Then a packet with source 192.168.1.100.
  - Expect: allowed, hit_idx=1.
- Destination match and default:
  - Setup: DEFAULT_ALLOW=0; entry0 = {dst 1, 0A000001, FFFFFFFF, allow 1}. Send a packet with dst 10.0.0.1, then one with dst 10.0.0.2.
  - Expect: first allowed with hit=1; second blocked with hit=0.
- Runt:
  - Setup: a 20-byte packet.
  - Expect: packet_allowed=0, runt=1, hit=0, done pulses once.
- Back-to-back with stalls:
  - Setup: three 40-byte packets with no gap, random valid_in deassertion, and a rule write in the cycle of a last_in.
  - Expect: exactly 3 done pulses with correct verdicts; the same-cycle write is not applied to that packet.
- Reset mid-packet:
  - Setup: rst at byte 15.
  - Expect: no done, all outputs 0, rule table cleared. With FILTER_STATS_EN, counters read 0; after 2 allowed and 1 blocked packet, allow_count=2 and block_count=1.
